// File: rtl/dmem_map_pkg.sv
// Shared address map for the data-memory / MMIO responder: region nibbles,
// MMIO word offsets and the STATUS register layout.
package dmem_map_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TIME_W = 64;
  localparam int unsigned OFF_W  = 3;

  localparam logic [3:0] REGION_RAM          = 4'h0;
  localparam logic [3:0] REGION_MMIO_DEFAULT = 4'h1;

  localparam logic [OFF_W-1:0] OFF_TXDATA  = 3'd0;
  localparam logic [OFF_W-1:0] OFF_STATUS  = 3'd1;
  localparam logic [OFF_W-1:0] OFF_TIME_LO = 3'd2;
  localparam logic [OFF_W-1:0] OFF_TIME_HI = 3'd3;
  localparam logic [OFF_W-1:0] OFF_CMP     = 3'd4;

  localparam int unsigned ST_EMPTY = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_IRQ   = 2;
  localparam int unsigned ST_OVF   = 3;

  typedef struct packed {
    logic ovf;
    logic irq;
    logic full;
    logic empty;
  } status_t;

endpackage

// File: rtl/dmem_mmio_tx_byte_fifo.sv
// Byte TX FIFO with valid/ready drain side; a push into a full FIFO is
// accepted only if a pop happens in the same cycle, otherwise it sets ovf.
module tx_byte_fifo
  import dmem_map_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [BYTE_W-1:0]        push_data,
  input  logic                     pop_rdy,
  input  logic                     ovf_clr,
  output logic [BYTE_W-1:0]        head_data,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              empty_c, full_c, pop_c, push_ok_c;

  // Next-state: pointer wrap is the natural PW-bit rollover.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q;
    empty_c   = (count_q == '0);
    full_c    = (count_q == CW'(DEPTH));
    pop_c     = pop_rdy && !empty_c;
    push_ok_c = push && (!full_c || pop_c);

    if (push_ok_c) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_ok_c) - CW'(pop_c);

    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (push && full_c && !pop_c) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = empty_c;
  assign full      = full_c;
  assign valid     = !empty_c;
  assign count     = count_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// M-stage data port responder: word RAM, 64-bit timer with compare IRQ and a
// byte TX FIFO, all decoded from the core's byte address.
module dmem_mmio_responder
  import dmem_map_pkg::*;
#(
  parameter int unsigned       RAM_AW     = 6,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = {REGION_MMIO_DEFAULT, 28'h0}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              timer_irq
);

  localparam int unsigned RAM_WORDS   = 2 ** RAM_AW;
  localparam logic [3:0]  REGION_MMIO = MMIO_BASE[31:28];

  logic [DATA_W-1:0] ram_q [RAM_WORDS];
  logic [TIME_W-1:0] time_q, time_d;
  logic [DATA_W-1:0] cmp_q, cmp_d;
  logic              irq_q, irq_d;

  logic [3:0]        region_c;
  logic [OFF_W-1:0]  off_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic              ram_hit_c, mmio_hit_c, mmio_wr_c;
  logic              push_c, ovf_clr_c, cmp_wr_c;

  logic              fifo_full, fifo_empty, fifo_ovf;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  status_t           status_c;

  // Address decode; low two bits and RAM alias bits are don't-care.
  always_comb begin
    region_c   = ALUResultM[31:28];
    off_c      = ALUResultM[4:2];
    ram_idx_c  = ALUResultM[RAM_AW+1:2];
    ram_hit_c  = (region_c == REGION_RAM);
    mmio_hit_c = (region_c == REGION_MMIO);
    mmio_wr_c  = MemWriteM && mmio_hit_c;
    push_c     = mmio_wr_c && (off_c == OFF_TXDATA);
    ovf_clr_c  = mmio_wr_c && (off_c == OFF_STATUS) && WriteDataM[ST_OVF];
    cmp_wr_c   = mmio_wr_c && (off_c == OFF_CMP);
  end

  always_ff @(posedge clk) begin
    if (MemWriteM && ram_hit_c) begin
      ram_q[ram_idx_c] <= WriteDataM;
    end
  end

  // A CMP write overrides a match in the same cycle, leaving irq clear.
  always_comb begin
    time_d = time_q + 64'd1;
    cmp_d  = cmp_q;
    irq_d  = irq_q;
    if (time_q[DATA_W-1:0] == cmp_q) begin
      irq_d = 1'b1;
    end
    if (cmp_wr_c) begin
      cmp_d = WriteDataM;
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      time_q <= '0;
      cmp_q  <= 32'hFFFF_FFFF;
      irq_q  <= 1'b0;
    end else begin
      time_q <= time_d;
      cmp_q  <= cmp_d;
      irq_q  <= irq_d;
    end
  end

  tx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push_c),
    .push_data (WriteDataM[BYTE_W-1:0]),
    .pop_rdy   (tx_ready),
    .ovf_clr   (ovf_clr_c),
    .head_data (tx_data),
    .valid     (tx_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .ovf       (fifo_ovf)
  );

  // Side-effect-free read mux.
  always_comb begin
    status_c.ovf   = fifo_ovf;
    status_c.irq   = irq_q;
    status_c.full  = fifo_full;
    status_c.empty = fifo_empty;
    ReadDataM      = '0;
    if (ram_hit_c) begin
      ReadDataM = ram_q[ram_idx_c];
    end else if (mmio_hit_c) begin
      case (off_c)
        OFF_STATUS:  ReadDataM = DATA_W'(status_c);
        OFF_TIME_LO: ReadDataM = time_q[DATA_W-1:0];
        OFF_TIME_HI: ReadDataM = time_q[TIME_W-1:DATA_W];
        OFF_CMP:     ReadDataM = cmp_q;
        default:     ReadDataM = '0;
      endcase
    end
  end

  assign timer_irq = irq_q;

  logic unused_bits;
  assign unused_bits = ^{ALUResultM[27:RAM_AW+2], ALUResultM[1:0], fifo_count};

endmodule
